// File: rtl/param_fetch_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : param_fetch_arbiter                                             |
// | Brief    : Round-robin burst arbiter sharing one fixed-latency parameter    |
// |            memory read port; optional stall counter via                     |
// |            PARAM_FETCH_ARB_STATS_EN.                                        |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module param_fetch_arbiter #(
    parameter  int NUM_REQ     = 6,
    parameter  int ADDR_WIDTH  = 16,
    parameter  int DATA_WIDTH  = 8,
    parameter  int MAX_BURST   = 100,
    parameter  int MEM_LATENCY = 2,
    localparam int LEN_W       = $clog2(MAX_BURST + 1),
    localparam int ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [ADDR_WIDTH-1:0] req_addr [NUM_REQ],
    input  logic [LEN_W-1:0]      req_len  [NUM_REQ],
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [NUM_REQ-1:0]    out_valid,
    input  logic [NUM_REQ-1:0]    out_ready,
    output logic                  busy,
    output logic [ID_W-1:0]       grant_id
`ifdef PARAM_FETCH_ARB_STATS_EN
    ,
    output logic [31:0]           stall_cycles
`endif
);

    localparam int FIFO_DEPTH = MEM_LATENCY + 2;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [ID_W-1:0]       r_rr_ptr, r_grant_id, w_winner, w_win_hi, w_win_lo;
    logic                  w_found_hi;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [LEN_W-1:0]      r_len, r_issued, w_len_clamped;
    logic [MEM_LATENCY-1:0] r_vpipe;
    logic [CNT_W-1:0]      r_inflight, r_count;
    logic [PTR_W-1:0]      r_wr_ptr, r_rd_ptr;
    logic [DATA_WIDTH-1:0] r_fifo [FIFO_DEPTH];
    logic                  w_accept, w_rd_en, w_push, w_pop, w_drain_done;

    function automatic logic [ID_W-1:0] f_next_id(input logic [ID_W-1:0] v);
        return (v == ID_W'(NUM_REQ - 1)) ? '0 : v + ID_W'(1);
    endfunction

    function automatic logic [PTR_W-1:0] f_next_ptr(input logic [PTR_W-1:0] v);
        return (v == PTR_W'(FIFO_DEPTH - 1)) ? '0 : v + PTR_W'(1);
    endfunction

    // Downward scan: the last hit is the lowest index, both at/after rr_ptr and overall.
    always_comb begin
        w_found_hi = 1'b0;
        w_win_hi   = '0;
        w_win_lo   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                w_win_lo = ID_W'(i);
                if (ID_W'(i) >= r_rr_ptr) begin
                    w_found_hi = 1'b1;
                    w_win_hi   = ID_W'(i);
                end
            end
        end
        w_winner = w_found_hi ? w_win_hi : w_win_lo;
    end

    assign w_accept      = (r_state == S_IDLE) && (|req_valid);
    assign w_len_clamped = (req_len[w_winner] > LEN_W'(MAX_BURST)) ? LEN_W'(MAX_BURST)
                                                                   : req_len[w_winner];
    // Credits cover every word that is either in flight or parked in the FIFO.
    assign w_rd_en       = (r_state == S_ISSUE) &&
                           ((int'(r_inflight) + int'(r_count)) < FIFO_DEPTH);
    assign w_push        = r_vpipe[MEM_LATENCY-1];
    assign w_pop         = (r_count != '0) && out_ready[r_grant_id];
    assign w_drain_done  = (r_state == S_DRAIN) && (r_inflight == '0) && (r_count == '0);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = (w_len_clamped == '0) ? S_IDLE : S_ISSUE;
            S_ISSUE: if (w_rd_en && (r_issued + LEN_W'(1) == r_len)) w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_drain_done) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= '0;
            r_grant_id <= '0;
            r_base     <= '0;
            r_len      <= '0;
            r_issued   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_grant_id <= w_winner;
                r_base     <= req_addr[w_winner];
                r_len      <= w_len_clamped;
                r_issued   <= '0;
                if (w_len_clamped == '0) r_rr_ptr <= f_next_id(w_winner);
            end
            if (w_rd_en)      r_issued <= r_issued + LEN_W'(1);
            if (w_drain_done) r_rr_ptr <= f_next_id(r_grant_id);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vpipe    <= '0;
            r_inflight <= '0;
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else begin
            r_vpipe    <= MEM_LATENCY'({r_vpipe, w_rd_en});
            r_inflight <= r_inflight + CNT_W'(w_rd_en) - CNT_W'(w_push);
            r_count    <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            if (w_push) r_wr_ptr <= f_next_ptr(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= f_next_ptr(r_rd_ptr);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wr_ptr] <= mem_rd_data;
    end

    // req_ready is combinational from req_valid, so it is masked while reset is held.
    assign req_ready   = (w_accept && rst) ? (NUM_REQ'(1) << w_winner) : '0;
    assign mem_rd_en   = w_rd_en;
    assign mem_rd_addr = w_rd_en ? (r_base + ADDR_WIDTH'(r_issued)) : '0;
    assign out_data    = (r_count != '0) ? r_fifo[r_rd_ptr] : '0;
    assign out_valid   = (r_count != '0) ? (NUM_REQ'(1) << r_grant_id) : '0;
    assign busy        = (r_state != S_IDLE);
    assign grant_id    = r_grant_id;

`ifdef PARAM_FETCH_ARB_STATS_EN
    logic [31:0] r_stall_cycles;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cycles <= '0;
        end else if ((r_count != '0) && !out_ready[r_grant_id] && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`endif

endmodule
`default_nettype wire

// File: tb/tb_param_fetch_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_param_fetch_arbiter                                          |
// | Brief    : Directed self-checking bench for param_fetch_arbiter.           |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_param_fetch_arbiter;

    localparam int NUM_REQ     = 6;
    localparam int ADDR_WIDTH  = 16;
    localparam int DATA_WIDTH  = 8;
    localparam int MAX_BURST   = 100;
    localparam int MEM_LATENCY = 2;
    localparam int LEN_W       = $clog2(MAX_BURST + 1);
    localparam int ID_W        = $clog2(NUM_REQ);

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic [NUM_REQ-1:0]    req_valid;
    logic [ADDR_WIDTH-1:0] req_addr [NUM_REQ];
    logic [LEN_W-1:0]      req_len  [NUM_REQ];
    logic [NUM_REQ-1:0]    req_ready;
    logic                  mem_rd_en;
    logic [ADDR_WIDTH-1:0] mem_rd_addr;
    logic [DATA_WIDTH-1:0] mem_rd_data;
    logic [DATA_WIDTH-1:0] out_data;
    logic [NUM_REQ-1:0]    out_valid;
    logic [NUM_REQ-1:0]    out_ready;
    logic                  busy;
    logic [ID_W-1:0]       grant_id;
`ifdef PARAM_FETCH_ARB_STATS_EN
    logic [31:0]           stall_cycles;
    logic [31:0]           stall_base;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int n_reads, n_words, n_stall, n_cyc;
    int order [$];
    logic saw_stall, prev_hold, exp_issue;
    logic [DATA_WIDTH-1:0] prev_data;
    logic [ADDR_WIDTH-1:0] exp_wrap [4];
    logic [DATA_WIDTH-1:0] mem_pipe [MEM_LATENCY];

    param_fetch_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_len     (req_len),
        .req_ready   (req_ready),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .grant_id    (grant_id)
`ifdef PARAM_FETCH_ARB_STATS_EN
        ,
        .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    // Memory model: returns the low address byte MEM_LATENCY cycles after the read.
    always @(posedge clk) begin
        mem_pipe[0] <= mem_rd_addr[DATA_WIDTH-1:0];
        for (int i = 1; i < MEM_LATENCY; i++) mem_pipe[i] <= mem_pipe[i-1];
    end
    assign mem_rd_data = mem_pipe[MEM_LATENCY-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 300) begin
            tick();
            sample();
            n++;
        end
        chk(tag, 32'(busy), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_mem_rd_en"}, 32'(mem_rd_en), 32'd0);
        chk({tag, "_mem_rd_addr"}, 32'(mem_rd_addr), 32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_data"}, 32'(out_data), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_grant_id"}, 32'(grant_id), 32'd0);
`ifdef PARAM_FETCH_ARB_STATS_EN
        chk({tag, "_stall_cycles"}, stall_cycles, 32'd0);
`endif
    endtask

    initial begin
        exp_wrap = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        out_ready = '1;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_addr[i] = ADDR_WIDTH'(16'h0020 + i);
            req_len[i]  = LEN_W'(1);
        end
        // Requests held during reset must not be acknowledged.
        req_valid = '1;
        repeat (2) @(posedge clk);
        sample();
        chk_all_zero("reset");

        // Round-robin: all sources request len 1 continuously from rr_ptr=0.
        tick();
        rst = 1'b1;
        n_cyc = 0;
        while (order.size() < 7 && n_cyc < 100) begin
            sample();
            if (req_ready != '0) begin
                chk("rr_onehot", 32'($onehot(req_ready)), 32'd1);
                for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) order.push_back(i);
            end
            tick();
            n_cyc++;
        end
        req_valid = '0;
        chk("rr_grant_count", 32'(order.size()), 32'd7);
        for (int k = 0; k < order.size(); k++) chk("rr_order", 32'(order[k]), 32'(k % NUM_REQ));
        sample();
        wait_idle("rr_idle");

        // Single request: src 2, addr 0x10, len 4 (rr_ptr now 1).
        tick();
        req_valid = 6'b000100;
        req_addr[2] = 16'h0010;
        req_len[2]  = LEN_W'(4);
        sample();
        chk("single_req_ready", 32'(req_ready), 32'h04);
        chk("single_busy_t0", 32'(busy), 32'd0);
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (k == 1) req_valid = '0;
            sample();
            if (k <= 4) begin
                chk("single_rd_en", 32'(mem_rd_en), 32'd1);
                chk("single_rd_addr", 32'(mem_rd_addr), 32'(16'h0010 + k - 1));
            end
            if (k == 1) begin
                chk("single_busy", 32'(busy), 32'd1);
                chk("single_grant_id", 32'(grant_id), 32'd2);
            end
            if (k <= 3) chk("single_no_early_valid", 32'(out_valid), 32'd0);
            if (k >= 4 && k <= 7) begin
                chk("single_out_valid", 32'(out_valid), 32'h04);
                chk("single_out_data", 32'(out_data), 32'(8'h10 + k - 4));
            end
            if (k == 5) chk("single_rd_stop", 32'(mem_rd_en), 32'd0);
            if (k == 8) chk("single_valid_end", 32'(out_valid), 32'd0);
            if (k == 9) chk("single_busy_drop", 32'(busy), 32'd0);
        end

        // Zero length from src 1, then src 2 wins next (rr_ptr 3 before this).
        tick();
        req_valid  = 6'b000110;
        req_len[1] = '0;
        req_len[2] = LEN_W'(1);
        req_addr[2] = 16'h0040;
        sample();
        chk("zero_req_ready", 32'(req_ready), 32'h02);
        chk("zero_no_rd", 32'(mem_rd_en), 32'd0);
        tick();
        sample();
        chk("zero_next_grant", 32'(req_ready), 32'h04);
        chk("zero_no_rd2", 32'(mem_rd_en), 32'd0);
        chk("zero_grant_id", 32'(grant_id), 32'd1);
        tick();
        req_valid = '0;
        sample();
        chk("zero_next_rd_addr", 32'(mem_rd_addr), 32'h0040);
        chk("zero_next_grant_id", 32'(grant_id), 32'd2);
        wait_idle("zero_idle");

        // Clamp: req_len 120 on src 3 delivers exactly MAX_BURST words.
        tick();
        req_valid   = 6'b001000;
        req_addr[3] = 16'h0100;
        req_len[3]  = LEN_W'(120);
        sample();
        chk("clamp_req_ready", 32'(req_ready), 32'h08);
        n_reads = 0;
        n_words = 0;
        for (int c = 1; c <= 110; c++) begin
            tick();
            if (c == 1) req_valid = '0;
            sample();
            if (mem_rd_en) n_reads++;
            if (out_valid[3]) begin
                chk("clamp_data", 32'(out_data), 32'(DATA_WIDTH'(n_words)));
                n_words++;
            end
        end
        chk("clamp_reads", 32'(n_reads), 32'd100);
        chk("clamp_words", 32'(n_words), 32'd100);
        chk("clamp_idle", 32'(busy), 32'd0);

        // Address wrap on src 4.
        tick();
        req_valid   = 6'b010000;
        req_addr[4] = 16'hFFFE;
        req_len[4]  = LEN_W'(4);
        sample();
        chk("wrap_req_ready", 32'(req_ready), 32'h10);
        n_reads = 0;
        n_words = 0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (c == 1) req_valid = '0;
            sample();
            if (mem_rd_en) begin
                if (n_reads < 4) chk("wrap_addr", 32'(mem_rd_addr), 32'(exp_wrap[n_reads]));
                n_reads++;
            end
            if (out_valid[4]) begin
                if (n_words < 4) chk("wrap_data", 32'(out_data), 32'(exp_wrap[n_words][7:0]));
                n_words++;
            end
        end
        chk("wrap_reads", 32'(n_reads), 32'd4);
        chk("wrap_words", 32'(n_words), 32'd4);
        wait_idle("wrap_idle");

        // Backpressure on src 5: out_ready 1,0,0 repeating.
`ifdef PARAM_FETCH_ARB_STATS_EN
        stall_base = stall_cycles;
`endif
        tick();
        req_valid   = 6'b100000;
        req_addr[5] = 16'h0080;
        req_len[5]  = LEN_W'(8);
        sample();
        chk("bp_req_ready", 32'(req_ready), 32'h20);
        n_reads   = 0;
        n_words   = 0;
        n_stall   = 0;
        saw_stall = 1'b0;
        prev_hold = 1'b0;
        prev_data = '0;
        for (int c = 1; c <= 60; c++) begin
            tick();
            if (c == 1) req_valid = '0;
            out_ready[5] = (c % 3 == 0);
            sample();
            if (n_reads < 8) begin
                exp_issue = (n_reads - n_words) < 4;
                chk("bp_issue", 32'(mem_rd_en), 32'(exp_issue));
                if (!mem_rd_en) saw_stall = 1'b1;
            end
            if (prev_hold) begin
                chk("bp_hold_valid", 32'(out_valid), 32'h20);
                chk("bp_hold_data", 32'(out_data), 32'(prev_data));
            end
            if (out_valid[5]) begin
                if (out_ready[5]) begin
                    chk("bp_data", 32'(out_data), 32'(8'h80 + n_words));
                    n_words++;
                end else begin
                    n_stall++;
                end
            end
            prev_hold = out_valid[5] && !out_ready[5];
            prev_data = out_data;
            if (mem_rd_en) n_reads++;
        end
        chk("bp_words", 32'(n_words), 32'd8);
        chk("bp_saw_stall", 32'(saw_stall), 32'd1);
`ifdef PARAM_FETCH_ARB_STATS_EN
        chk("bp_stall_cycles", stall_cycles - stall_base, 32'(n_stall));
`endif
        out_ready = '1;
        wait_idle("bp_idle");

        // Reset during word 3 of a len-10 burst on src 3 (rr_ptr 0 before this).
        tick();
        req_valid   = 6'b001000;
        req_addr[3] = 16'h0050;
        req_len[3]  = LEN_W'(10);
        sample();
        chk("mid_req_ready", 32'(req_ready), 32'h08);
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c == 1) req_valid = '0;
            if (c == 6) rst = 1'b0;
            sample();
            if (c == 4 || c == 5) chk("mid_data", 32'(out_data), 32'(8'h50 + c - 4));
        end
        chk_all_zero("mid_reset");
        tick();
        rst = 1'b1;
        for (int c = 0; c < 5; c++) begin
            sample();
            chk("post_rst_no_valid", 32'(out_valid), 32'd0);
            chk("post_rst_idle", 32'(busy), 32'd0);
            tick();
        end
        // src 0 and src 4 both request: src 0 must win with rr_ptr back at 0.
        req_valid   = 6'b010001;
        req_addr[0] = 16'h0030;
        req_len[0]  = LEN_W'(2);
        sample();
        chk("post_rst_grant", 32'(req_ready), 32'h01);
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c == 1) req_valid = '0;
            sample();
            if (c == 4 || c == 5) begin
                chk("post_rst_valid", 32'(out_valid), 32'h01);
                chk("post_rst_data", 32'(out_data), 32'(8'h30 + c - 4));
            end
            if (c == 6) chk("post_rst_end", 32'(out_valid), 32'd0);
        end
        wait_idle("post_rst_idle");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/param_fetch_arbiter.md
Name: param_fetch_arbiter

Overview:
- Shares one fixed-latency parameter-memory read port among NUM_REQ parameter sources (fcN weight/bias streamers).
- Each source issues a burst request: base address plus length. The arbiter grants requests round-robin, issues the reads, and streams the returned words back to the granted source over a valid/ready handshake.
- Sits between the per-layer weight/bias sources and the on-chip parameter memory inside the top-level memory-mapped wrapper.

Parameters:
- NUM_REQ, 6, number of requesting sources.
- ADDR_WIDTH, 16, parameter-memory word address width.
- DATA_WIDTH, 8, memory word width; equals the weight/bias PRECISION_0.
- MAX_BURST, 100, maximum words per burst.
- MEM_LATENCY, 2, fixed cycles from mem_rd_en to mem_rd_data valid (≥1).
- Localparam LEN_W = $clog2(MAX_BURST+1).
- Localparam FIFO_DEPTH = MEM_LATENCY+2.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-source burst request.
- req_addr  in  NUM_REQ x ADDR_WIDTH  burst base address, unpacked array.
- req_len  in  NUM_REQ x LEN_W  burst length in words, unpacked array.
- req_ready  out  NUM_REQ  one-hot, 1-cycle pulse: request accepted.
- mem_rd_en  out  1  memory read strobe.
- mem_rd_addr  out  ADDR_WIDTH  memory read address.
- mem_rd_data  in  DATA_WIDTH  read data, valid MEM_LATENCY cycles after mem_rd_en.
- out_data  out  DATA_WIDTH  returned word, shared by all sources.
- out_valid  out  NUM_REQ  one-hot; set only for the granted source.
- out_ready  in  NUM_REQ  per-source sink ready.
- busy  out  1  high in any state other than IDLE.
- grant_id  out  $clog2(NUM_REQ)  index of the current or last grant.

Behaviour:
- Reset (rst=0, async): all outputs 0. State IDLE, rr_ptr=0, FIFO empty, read-valid shift pipe cleared.
- FSM: IDLE -> ISSUE -> DRAIN -> IDLE.
- IDLE, arbitration:
  - Scan req_valid starting at index rr_ptr, wrapping; lowest index at or after rr_ptr wins.
  - Same cycle: req_ready[winner]=1; latch addr, len, grant_id.
  - Length clamp: len=min(req_len, MAX_BURST).
  - len==0: go directly back to IDLE; rr_ptr=winner+1 mod NUM_REQ; no reads issued.
  - Otherwise go to ISSUE.
- ISSUE:
  - mem_rd_en=1 when inflight+fifo_count < FIFO_DEPTH.
  - mem_rd_addr = base + issued_count, modulo 2^ADDR_WIDTH (wraps 0xFFFF -> 0x0000).
  - When issued_count reaches len, go to DRAIN.
- Return path:
  - A MEM_LATENCY-deep valid shift pipe tags returning data.
  - Tagged data is written into the FIFO; the FIFO is never full on write because of the credit rule above.
- Output:
  - out_data = FIFO head.
  - out_valid[grant_id] = FIFO nonempty; all other bits 0.
  - Pop on out_valid & out_ready[grant_id].
- DRAIN: when inflight==0 and FIFO empty, go to IDLE and set rr_ptr=grant_id+1 mod NUM_REQ.
- Latency: acceptance at cycle T; first mem_rd_en at T+1; first out_valid at T+2+MEM_LATENCY.
  - With out_ready held high: 1 word/cycle, last word at T+1+MEM_LATENCY+len.
  - Next grant is no earlier than 1 cycle after DRAIN exits.
- Backpressure: out_valid and out_data are held stable while out_ready is low. Issue stalls once credits are exhausted; no word is ever dropped.
- req_valid may deassert at any time. Requests are only sampled in IDLE; changes to req_addr/req_len after acceptance are ignored.
- Simultaneous requests from all sources: each is served exactly once per NUM_REQ grants (strict round-robin).
- Reset mid-burst: burst abandoned immediately. Memory data arriving after reset release is ignored because the pipe has been cleared.

Optional Feature:
- Macro: PARAM_FETCH_ARB_STATS_EN.
- Defined: adds output stall_cycles (32-bit). It increments each cycle FIFO is nonempty and out_ready[grant_id]==0, saturates at 0xFFFFFFFF, and is cleared by rst.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Single request: src 2, addr 0x0010, len 4, out_ready=1, memory returns addr LSBs -> req_ready[2] at T; out_valid[2] for 4 consecutive cycles from T+4 with data 0x10, 0x11, 0x12, 0x13; busy drops after the last word.
- Round-robin: all six sources request len 1 continuously -> grant order 0,1,2,3,4,5,0; each req_ready exactly once per six grants.
- Backpressure: len 8; out_ready toggles 1,0,0,1,... -> all 8 words delivered in order with none lost; mem_rd_en stalls once inflight+fifo_count=4; with stats enabled, stall_cycles equals the count of low-ready cycles while valid.
- Zero length and clamp: src 1 len 0 -> req_ready[1] pulse, no mem_rd_en, next grant goes to src 2. req_len=120 -> exactly 100 words delivered.
- Address wrap: addr 0xFFFE, len 4 -> mem_rd_addr sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Reset mid-burst: assert rst low during word 3 of a len-10 burst -> all outputs 0 immediately; after release, no stale out_valid; a new request from src 0 is served normally with rr_ptr=0.
